// File: rtl/aes_dec_round_ctrl_if.sv
// Host/datapath handshake bundle for the AES-128 decrypt round sequencer.
interface aes_dec_round_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 4
) ();

  logic                 start;
  logic                 abort;
  logic                 key_valid;
  logic [CNT_WIDTH-1:0] round_count;
  logic                 key_req;
  logic                 load_state;
  logic                 round_en;
  logic                 inv_sub_en;
  logic                 inv_mix_en;
  logic                 last_round;
  logic                 busy;
  logic                 done;

  // Host and key store drive requests; they observe the sequencer's decode.
  modport master (
    output start, abort, key_valid,
    input  round_count, key_req, load_state, round_en,
    input  inv_sub_en, inv_mix_en, last_round, busy, done
  );

  // The sequencer itself.
  modport slave (
    input  start, abort, key_valid,
    output round_count, key_req, load_state, round_en,
    output inv_sub_en, inv_mix_en, last_round, busy, done
  );

endinterface

// File: rtl/aes_dec_round_ctrl.sv
// AES-128 decrypt round sequencer: walks the round key index NUM_ROUNDS..0,
// one round per accepted key, and decodes the inverse-round datapath enables.
module aes_dec_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  aes_dec_round_ctrl_if.slave  bus
);

  localparam logic [CNT_WIDTH-1:0] FIRST_CNT = CNT_WIDTH'(NUM_ROUNDS);
  localparam logic [CNT_WIDTH-1:0] ZERO_CNT  = '0;
  localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);

  generate
    if ((2 ** CNT_WIDTH) <= NUM_ROUNDS) begin : g_bad_width
      $error("CNT_WIDTH too small to hold NUM_ROUNDS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] round_count;
  logic [CNT_WIDTH-1:0] round_count_nxt;

  // State and round index registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      round_count <= FIRST_CNT;
    end else begin
      state       <= state_nxt;
      round_count <= round_count_nxt;
    end
  end

  // Next-state logic; abort outranks key_valid and start in every busy state.
  always_comb begin
    state_nxt       = state;
    round_count_nxt = round_count;
    unique case (state)
      IDLE: begin
        round_count_nxt = FIRST_CNT;
        if (bus.start) state_nxt = LOAD;
      end
      LOAD: begin
        if (bus.abort) begin
          state_nxt       = IDLE;
          round_count_nxt = FIRST_CNT;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt       = IDLE;
          round_count_nxt = FIRST_CNT;
        end else if (bus.key_valid) begin
          if (round_count == ZERO_CNT) begin
            state_nxt       = DONE;
            round_count_nxt = FIRST_CNT;
          end else begin
            round_count_nxt = round_count - ONE_CNT;
          end
        end
      end
      DONE: begin
        state_nxt       = IDLE;
        round_count_nxt = FIRST_CNT;
      end
      default: begin
        state_nxt       = IDLE;
        round_count_nxt = FIRST_CNT;
      end
    endcase
  end

  logic in_run;
  logic fire;
  logic is_first;
  logic is_last;

  assign in_run   = (state == RUN);
  assign fire     = in_run && bus.key_valid;
  assign is_first = (round_count == FIRST_CNT);
  assign is_last  = (round_count == ZERO_CNT);

  // Output decode; the first round is AddRoundKey only, the last skips InvMixColumns.
  assign bus.round_count = round_count;
  assign bus.key_req     = in_run;
  assign bus.load_state  = (state == LOAD);
  assign bus.round_en    = fire;
  assign bus.inv_sub_en  = fire && !is_first;
  assign bus.inv_mix_en  = fire && !is_first && !is_last;
  assign bus.last_round  = in_run && is_last;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);

  a_count_range: assert property (@(posedge clk) disable iff (!n_rst)
    round_count <= FIRST_CNT);

  a_done_from_run: assert property (@(posedge clk) disable iff (!n_rst)
    (state == DONE) |-> ($past(state) == RUN));

  a_load_from_idle: assert property (@(posedge clk) disable iff (!n_rst)
    (state == LOAD) |-> ($past(state) == IDLE));

  a_idle_count: assert property (@(posedge clk) disable iff (!n_rst)
    (state == IDLE) |-> (round_count == FIRST_CNT));

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Directed bench for aes_dec_round_ctrl with hand-derived per-cycle expectations.
module tb_aes_dec_round_ctrl;

  logic clk;
  logic n_rst;
  int   n_checks;
  int   n_pass;

  aes_dec_round_ctrl_if #(.CNT_WIDTH(4)) bus ();

  aes_dec_round_ctrl #(
    .NUM_ROUNDS(10),
    .CNT_WIDTH (4)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic kv, input logic ab);
    bus.start     = s;
    bus.key_valid = kv;
    bus.abort     = ab;
    #1;
  endtask

  // Start a block from IDLE; returns at cycle 1 (LOAD) with start dropped.
  task automatic kick(input logic kv);
    drive(1'b1, kv, 1'b0);
    tick();
    drive(1'b0, kv, 1'b0);
  endtask

  function automatic int exp_cnt_plain(input int c);
    if (c <= 2) return 10;
    if (c <= 12) return 12 - c;
    return 10;
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n_rst    = 1'b0;
    bus.start     = 1'b0;
    bus.key_valid = 1'b0;
    bus.abort     = 1'b0;
    #23;
    n_rst = 1'b1;
    tick();

    check("rst_count", 32'(bus.round_count), 32'd10);
    check("rst_busy",  32'(bus.busy),        32'd0);
    check("rst_done",  32'(bus.done),        32'd0);
    check("rst_kreq",  32'(bus.key_req),     32'd0);

    // Abort while idle must not change anything.
    drive(1'b0, 1'b1, 1'b1);
    tick();
    check("idle_abort_busy", 32'(bus.busy),        32'd0);
    check("idle_abort_cnt",  32'(bus.round_count), 32'd10);
    check("idle_kv_ren",     32'(bus.round_en),    32'd0);
    drive(1'b0, 1'b0, 1'b0);

    // T1: reset asserted mid-RUN at count 5 (cycle 7).
    kick(1'b1);
    for (int c = 2; c <= 7; c++) tick();
    check("t1_pre_cnt", 32'(bus.round_count), 32'd5);
    n_rst = 1'b0;
    #1;
    check("t1_cnt",  32'(bus.round_count), 32'd10);
    check("t1_busy", 32'(bus.busy),        32'd0);
    check("t1_kreq", 32'(bus.key_req),     32'd0);
    check("t1_done", 32'(bus.done),        32'd0);
    drive(1'b0, 1'b0, 1'b0);
    #2;
    n_rst = 1'b1;
    tick();
    check("t1_after_busy", 32'(bus.busy), 32'd0);

    // T2/T3: full block, key_valid held high.
    kick(1'b1);
    for (int c = 1; c <= 14; c++) begin
      check($sformatf("t2_load_c%0d", c), 32'(bus.load_state),  32'(c == 1));
      check($sformatf("t2_ren_c%0d", c),  32'(bus.round_en),    32'(c >= 2 && c <= 12));
      check($sformatf("t2_kreq_c%0d", c), 32'(bus.key_req),     32'(c >= 2 && c <= 12));
      check($sformatf("t2_cnt_c%0d", c),  32'(bus.round_count), 32'(exp_cnt_plain(c)));
      check($sformatf("t3_sub_c%0d", c),  32'(bus.inv_sub_en),  32'(c >= 3 && c <= 12));
      check($sformatf("t3_mix_c%0d", c),  32'(bus.inv_mix_en),  32'(c >= 3 && c <= 11));
      check($sformatf("t3_last_c%0d", c), 32'(bus.last_round),  32'(c == 12));
      check($sformatf("t2_done_c%0d", c), 32'(bus.done),        32'(c == 13));
      check($sformatf("t2_busy_c%0d", c), 32'(bus.busy),        32'(c <= 13));
      tick();
    end

    // T4: key_valid low for cycles 6..8 while count sits at 6.
    kick(1'b1);
    for (int c = 1; c <= 17; c++) begin
      int  ec;
      logic kv;
      kv = !(c >= 6 && c <= 8);
      drive(1'b0, kv, 1'b0);
      if (c <= 2)       ec = 10;
      else if (c <= 6)  ec = 12 - c;
      else if (c <= 8)  ec = 6;
      else if (c <= 15) ec = 15 - c;
      else              ec = 10;
      check($sformatf("t4_cnt_c%0d", c),  32'(bus.round_count), 32'(ec));
      check($sformatf("t4_ren_c%0d", c),  32'(bus.round_en),    32'((c >= 2 && c <= 5) || (c >= 9 && c <= 15)));
      check($sformatf("t4_sub_c%0d", c),  32'(bus.inv_sub_en),  32'((c >= 3 && c <= 5) || (c >= 9 && c <= 15)));
      check($sformatf("t4_done_c%0d", c), 32'(bus.done),        32'(c == 16));
      check($sformatf("t4_busy_c%0d", c), 32'(bus.busy),        32'(c <= 16));
      tick();
    end

    // T5: abort at count 4 (cycle 8) together with key_valid.
    drive(1'b0, 1'b0, 1'b0);
    kick(1'b1);
    for (int c = 2; c <= 8; c++) tick();
    check("t5_pre_cnt", 32'(bus.round_count), 32'd4);
    drive(1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    check("t5_cnt",  32'(bus.round_count), 32'd10);
    check("t5_busy", 32'(bus.busy),        32'd0);
    check("t5_done", 32'(bus.done),        32'd0);
    tick();
    check("t5_idle_done", 32'(bus.done), 32'd0);
    kick(1'b1);
    for (int c = 1; c <= 14; c++) begin
      check($sformatf("t5_cnt_c%0d", c),  32'(bus.round_count), 32'(exp_cnt_plain(c)));
      check($sformatf("t5_ren_c%0d", c),  32'(bus.round_en),    32'(c >= 2 && c <= 12));
      check($sformatf("t5_done_c%0d", c), 32'(bus.done),        32'(c == 13));
      tick();
    end

    // T6: start re-pulsed in RUN (cycle 5) and in DONE (cycle 13).
    kick(1'b1);
    for (int c = 1; c <= 16; c++) begin
      drive((c == 5) || (c == 13), 1'b1, 1'b0);
      check($sformatf("t6_load_c%0d", c), 32'(bus.load_state),  32'(c == 1));
      check($sformatf("t6_cnt_c%0d", c),  32'(bus.round_count), 32'(exp_cnt_plain(c)));
      check($sformatf("t6_done_c%0d", c), 32'(bus.done),        32'(c == 13));
      check($sformatf("t6_busy_c%0d", c), 32'(bus.busy),        32'(c <= 13));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
